// File: rtl/lsu_pkg.sv
// Shared encodings for the sub-word load/store unit.
//   SZ_*  : request size field (req_size_i); value 3 is reserved and
//           always rejected as misaligned.
//   ST_*  : read-modify-write sequencer states.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_MERGE = 1'b1;

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane insert: replaces the byte or halfword selected by
// lane_i/size_i inside word_i with the low bits of data_i (little-endian,
// lane 0 = bits [7:0]). A word-sized insert returns data_i unchanged.
// Ports:
//   word_i   : original memory word
//   lane_i   : byte offset within the word
//   size_i   : SZ_BYTE / SZ_HALF / SZ_WORD
//   data_i   : store data, low bits used for sub-word sizes
//   merged_o : word with the target lane replaced
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] data_i,
    output logic [31:0] merged_o
);

    // Lane replacement; unsupported sizes leave the word untouched.
    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (lane_i)
                    2'd0:    merged_o[7:0]   = data_i[7:0];
                    2'd1:    merged_o[15:8]  = data_i[7:0];
                    2'd2:    merged_o[23:16] = data_i[7:0];
                    2'd3:    merged_o[31:24] = data_i[7:0];
                    default: merged_o        = word_i;
                endcase
            end
            SZ_HALF: begin
                if (lane_i[1]) begin
                    merged_o[31:16] = data_i[15:0];
                end else begin
                    merged_o[15:0]  = data_i[15:0];
                end
            end
            SZ_WORD: merged_o = data_i;
            default: merged_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit adding byte/half/word loads and stores on top of a
// word-only, little-endian data memory (combinational read, write on posedge).
// Sub-word stores run as a read-modify-write: the IDLE cycle reads the word
// and stalls, the MERGE cycle writes the merged word back.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid_i/write/size/unsigned/addr/wdata : memory request from datapath
//   rdata_o                 : extended load result
//   stall_o                 : hold PC during the read phase of an RMW
//   misaligned_o, fault_o   : request rejected (alignment has priority)
//   mem_addr_o/wdata/read/write, mem_rdata_i : Data_Memory interface
module lsu_subword
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              misaligned_o,
    output logic              fault_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [31:0]       mem_rdata_i
);

    // One extra bit so the last-byte sum cannot wrap near the top of memory.
    localparam logic [ADDR_W:0] MEM_LIMIT_C = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] LAST_OFS_C  = (ADDR_W+1)'(3);

    logic [0:0]        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       merged_r;

    logic [ADDR_W-1:0] aligned_s;
    logic [1:0]        lane_s;
    logic [ADDR_W:0]   last_byte_s;
    logic              misaligned_s;
    logic              fault_s;
    logic              accept_s;
    logic              sub_store_s;
    logic [31:0]       merged_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [31:0]       load_data_s;

    assign aligned_s   = {req_addr_i[ADDR_W-1:2], 2'b00};
    assign lane_s      = req_addr_i[1:0];
    assign last_byte_s = {1'b0, aligned_s} + LAST_OFS_C;

    // Alignment and range classification of the incoming request.
    always_comb begin
        misaligned_s = 1'b0;
        case (req_size_i)
            SZ_BYTE: misaligned_s = 1'b0;
            SZ_HALF: misaligned_s = lane_s[0];
            SZ_WORD: misaligned_s = (lane_s != 2'd0);
            default: misaligned_s = 1'b1;
        endcase
        fault_s     = ~misaligned_s & (last_byte_s >= MEM_LIMIT_C);
        accept_s    = req_valid_i & ~misaligned_s & ~fault_s;
        sub_store_s = accept_s & req_write_i & (req_size_i != SZ_WORD);
    end

    // Load extraction: pick the lane and sign/zero extend.
    always_comb begin
        byte_s      = mem_rdata_i[7:0];
        half_s      = lane_s[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_data_s = 32'h0;
        case (lane_s)
            2'd0:    byte_s = mem_rdata_i[7:0];
            2'd1:    byte_s = mem_rdata_i[15:8];
            2'd2:    byte_s = mem_rdata_i[23:16];
            2'd3:    byte_s = mem_rdata_i[31:24];
            default: byte_s = mem_rdata_i[7:0];
        endcase
        case (req_size_i)
            SZ_BYTE: load_data_s = req_unsigned_i ? {24'h0, byte_s}
                                                  : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_data_s = req_unsigned_i ? {16'h0, half_s}
                                                  : {{16{half_s[15]}}, half_s};
            SZ_WORD: load_data_s = mem_rdata_i;
            default: load_data_s = 32'h0;
        endcase
    end

    lsu_lane_merge u_lane_merge (
        .word_i   (mem_rdata_i),
        .lane_i   (lane_s),
        .size_i   (req_size_i),
        .data_i   (req_wdata_i),
        .merged_o (merged_s)
    );

    // Output decode; reset forces every output low, which also drops a MERGE write.
    always_comb begin
        rdata_o      = 32'h0;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        fault_o      = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = 32'h0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        if (rst_i) begin
            mem_write_o = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        misaligned_o = misaligned_s;
                        fault_o      = fault_s;
                    end else begin
                        misaligned_o = 1'b0;
                    end
                    if (accept_s) begin
                        mem_addr_o = aligned_s;
                        if (!req_write_i) begin
                            mem_read_o = 1'b1;
                            rdata_o    = load_data_s;
                        end else if (req_size_i == SZ_WORD) begin
                            mem_write_o = 1'b1;
                            mem_wdata_o = req_wdata_i;
                        end else begin
                            // Read phase of the RMW; the CPU holds the instruction.
                            mem_read_o = 1'b1;
                            stall_o    = 1'b1;
                        end
                    end else begin
                        mem_addr_o = '0;
                    end
                end
                ST_MERGE: begin
                    // Request inputs are ignored: they still repeat the same store.
                    mem_write_o = 1'b1;
                    mem_addr_o  = addr_r;
                    mem_wdata_o = merged_r;
                end
                default: begin
                    mem_write_o = 1'b0;
                end
            endcase
        end
    end

    // RMW sequencer: capture address and merged word, then write back next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            addr_r   <= '0;
            merged_r <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sub_store_s) begin
                        state_r  <= ST_MERGE;
                        addr_r   <= aligned_s;
                        merged_r <= merged_s;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_MERGE: state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_write_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        stall_o, misaligned_o, fault_o, mem_read_o, mem_write_o;

    always #5 clk = ~clk;

    lsu_subword #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rdata_o(rdata_o), .stall_o(stall_o),
        .misaligned_o(misaligned_o), .fault_o(fault_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // Data_Memory stand-in: word read combinational, write on posedge.
    logic [7:0]  dmem [0:127];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'h0, pl_data = 32'h0;

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 4; i++) dmem[int'(pl_addr[6:0]) + i] <= pl_data[8*i +: 8];
        end else if (mem_write_o && mem_addr_o < 32'd125) begin
            for (int i = 0; i < 4; i++) dmem[int'(mem_addr_o[6:0]) + i] <= mem_wdata_o[8*i +: 8];
        end
    end

    always_comb begin
        mem_rdata_i = 32'h0;
        if (mem_addr_o < 32'd125) begin
            for (int i = 0; i < 4; i++) mem_rdata_i[8*i +: 8] = dmem[int'(mem_addr_o[6:0]) + i];
        end
    end

    // Reference model: plain byte array with the architectural semantics.
    logic [7:0]  ref_mem [0:127];
    logic [4:0]  e1_flags, e2_flags;   // {stall, read, write, misaligned, fault}
    logic [31:0] e1_addr, e1_rdata, e1_wdata, e2_addr, e2_wdata;
    logic [4:0]  c1_flags, c2_flags;
    logic [31:0] c1_addr, c1_rdata, c1_wdata, c2_addr, c2_wdata;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[int'(a[6:0]) + i];
        return w;
    endfunction

    task automatic model_access(input logic [31:0] addr, input logic [1:0] size,
                                input logic wr, input logic uns, input logic [31:0] wdata);
        int          nb;
        logic        mis, flt;
        logic [31:0] base, v;
        nb   = 1 << size;
        base = addr & ~32'd3;
        mis  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        flt  = !mis && (longint'(base) + 3 >= 128);
        e1_flags = 5'b0; e1_addr = 32'h0; e1_rdata = 32'h0; e1_wdata = 32'h0;
        e2_flags = 5'b0; e2_addr = 32'h0; e2_wdata = 32'h0;
        if (mis || flt) begin
            e1_flags = {3'b000, mis, flt};
        end else if (!wr) begin
            e1_flags = 5'b01000;
            e1_addr  = base;
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
            e1_rdata = v;
        end else begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            if (nb == 4) begin
                e1_flags = 5'b00100; e1_addr = base; e1_wdata = wdata;
            end else begin
                e1_flags = 5'b11000; e1_addr = base;
                e2_flags = 5'b00100; e2_addr = base; e2_wdata = ref_word(base);
            end
        end
    endtask

    // Present one request; follow a stall with the held second cycle.
    task automatic issue(input logic [31:0] addr, input logic [1:0] size,
                         input logic wr, input logic uns, input logic [31:0] wdata);
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = wr; req_size_i = size;
        req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
        #1;
        c1_flags = {stall_o, mem_read_o, mem_write_o, misaligned_o, fault_o};
        c1_addr = mem_addr_o; c1_rdata = rdata_o; c1_wdata = mem_wdata_o;
        c2_flags = 5'b0; c2_addr = 32'h0; c2_wdata = 32'h0;
        if (stall_o) begin
            @(negedge clk); #1;
            c2_flags = {stall_o, mem_read_o, mem_write_o, misaligned_o, fault_o};
            c2_addr = mem_addr_o; c2_wdata = mem_wdata_o;
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        req_valid_i = 1'b0;
        pl_en = 1'b1; pl_addr = a; pl_data = w;
        for (int i = 0; i < 4; i++) ref_mem[int'(a[6:0]) + i] = w[8*i +: 8];
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_i = 1'b1; req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'd2;
        req_unsigned_i = 1'b0; req_addr_i = 32'h10; req_wdata_i = 32'h0;
        #1;
        total_cnt++;
        if ({rdata_o, stall_o, misaligned_o, fault_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o} !== 101'h0)
            $display("FAIL reset_outputs: got rd=%h st=%b rdm=%b wr=%b, required all zero", rdata_o, stall_o, mem_read_o, mem_write_o);
        else pass_cnt++;
        @(negedge clk);
        rst_i = 1'b0; req_valid_i = 1'b0;
        #1;
        total_cnt++;
        if ({rdata_o, stall_o, misaligned_o, fault_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o} !== 101'h0)
            $display("FAIL idle_defaults: got rd=%h addr=%h rdm=%b wr=%b, required all zero", rdata_o, mem_addr_o, mem_read_o, mem_write_o);
        else pass_cnt++;
    endtask

    task automatic test_loads();
        logic [31:0] addr_t [4] = '{32'h10, 32'h11, 32'h11, 32'h12};
        logic [1:0]  size_t [4] = '{2'd2, 2'd0, 2'd0, 2'd1};
        logic        uns_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_t  [4] = '{32'h8899AABB, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899};
        set_word(32'h10, 32'h8899AABB);
        for (int i = 0; i < 4; i++) begin
            issue(addr_t[i], size_t[i], 1'b0, uns_t[i], 32'h0);
            total_cnt++;
            if (c1_rdata !== exp_t[i] || c1_flags !== 5'b01000 || c1_addr !== 32'h10)
                $display("FAIL load_%0d: got rd=%h flags=%b addr=%h, required rd=%h flags=01000 addr=00000010", i, c1_rdata, c1_flags, c1_addr, exp_t[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_sub_store();
        set_word(32'h20, 32'h11223344);
        model_access(32'h21, 2'd0, 1'b1, 1'b0, 32'hA5A5A55C);
        issue(32'h21, 2'd0, 1'b1, 1'b0, 32'hA5A5A55C);
        total_cnt++;
        if (c1_flags !== 5'b11000 || c1_addr !== 32'h20)
            $display("FAIL sb_read_phase: got flags=%b addr=%h, required flags=11000 addr=00000020", c1_flags, c1_addr);
        else pass_cnt++;
        total_cnt++;
        if (c2_flags !== 5'b00100 || c2_addr !== 32'h20 || c2_wdata !== 32'h11225C44)
            $display("FAIL sb_write_phase: got flags=%b addr=%h wd=%h, required flags=00100 addr=00000020 wd=11225c44", c2_flags, c2_addr, c2_wdata);
        else pass_cnt++;
        issue(32'h20, 2'd2, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (c1_rdata !== 32'h11225C44)
            $display("FAIL sb_readback: got %h, required 11225c44", c1_rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        set_word(32'h30, 32'h00002200);
        model_access(32'h32, 2'd1, 1'b1, 1'b0, 32'h0000BEEF);
        issue(32'h32, 2'd1, 1'b1, 1'b0, 32'h0000BEEF);
        total_cnt++;
        if (c1_flags !== 5'b11000 || c2_flags !== 5'b00100 || c2_wdata !== 32'hBEEF2200)
            $display("FAIL sh_rmw: got f1=%b f2=%b wd=%h, required f1=11000 f2=00100 wd=beef2200", c1_flags, c2_flags, c2_wdata);
        else pass_cnt++;
        model_access(32'h30, 2'd0, 1'b1, 1'b0, 32'h00000001);
        issue(32'h30, 2'd0, 1'b1, 1'b0, 32'h00000001);
        total_cnt++;
        if (c1_flags !== 5'b11000 || c2_flags !== 5'b00100 || c2_wdata !== 32'hBEEF2201)
            $display("FAIL sb_after_sh: got f1=%b f2=%b wd=%h, required f1=11000 f2=00100 wd=beef2201", c1_flags, c2_flags, c2_wdata);
        else pass_cnt++;
        issue(32'h30, 2'd2, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (c1_rdata !== 32'hBEEF2201)
            $display("FAIL b2b_readback: got %h, required beef2201", c1_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reject();
        issue(32'h13, 2'd1, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (c1_flags !== 5'b00010 || c1_rdata !== 32'h0 || c1_addr !== 32'h0)
            $display("FAIL lh_misaligned: got flags=%b rd=%h addr=%h, required flags=00010 rd=0 addr=0", c1_flags, c1_rdata, c1_addr);
        else pass_cnt++;
        model_access(32'h7C, 2'd2, 1'b1, 1'b0, 32'h0BADF00D);
        issue(32'h7C, 2'd2, 1'b1, 1'b0, 32'h0BADF00D);
        total_cnt++;
        if (c1_flags !== 5'b00100 || c1_wdata !== 32'h0BADF00D || c1_addr !== 32'h7C)
            $display("FAIL sw_top_word: got flags=%b wd=%h addr=%h, required flags=00100 wd=0badf00d addr=0000007c", c1_flags, c1_wdata, c1_addr);
        else pass_cnt++;
        issue(32'h80, 2'd2, 1'b1, 1'b0, 32'h12345678);
        total_cnt++;
        if (c1_flags !== 5'b00001)
            $display("FAIL sw_fault: got flags=%b, required 00001", c1_flags);
        else pass_cnt++;
        issue(32'h81, 2'd1, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (c1_flags !== 5'b00010)
            $display("FAIL misaligned_priority: got flags=%b, required 00010", c1_flags);
        else pass_cnt++;
        issue(32'h7C, 2'd2, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (c1_rdata !== 32'h0BADF00D)
            $display("FAIL top_word_readback: got %h, required 0badf00d", c1_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_merge();
        set_word(32'h40, 32'hCAFEF00D);
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'd0;
        req_unsigned_i = 1'b0; req_addr_i = 32'h41; req_wdata_i = 32'h77;
        #1;
        total_cnt++;
        if (stall_o !== 1'b1)
            $display("FAIL merge_rst_stall: got %b, required 1", stall_o);
        else pass_cnt++;
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        total_cnt++;
        if (mem_write_o !== 1'b0 || mem_wdata_o !== 32'h0 || stall_o !== 1'b0)
            $display("FAIL merge_rst_write: got wr=%b wd=%h st=%b, required 0", mem_write_o, mem_wdata_o, stall_o);
        else pass_cnt++;
        @(negedge clk);
        rst_i = 1'b0; req_valid_i = 1'b0;
        #1;
        total_cnt++;
        if ({stall_o, mem_read_o, mem_write_o, mem_addr_o} !== 35'h0)
            $display("FAIL merge_rst_idle: got st=%b rd=%b wr=%b addr=%h, required 0", stall_o, mem_read_o, mem_write_o, mem_addr_o);
        else pass_cnt++;
        issue(32'h40, 2'd2, 1'b0, 1'b0, 32'h0);
        total_cnt++;
        if (c1_rdata !== 32'hCAFEF00D)
            $display("FAIL merge_rst_mem: got %h, required cafef00d", c1_rdata);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [1:0]  sz;
        logic        wr, un;
        for (int n = 0; n < 80; n++) begin
            a  = $urandom_range(0, 135);
            sz = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            d  = $urandom;
            model_access(a, sz, wr, un, d);
            issue(a, sz, wr, un, d);
            total_cnt++;
            if (c1_flags !== e1_flags || c1_addr !== e1_addr || c1_rdata !== e1_rdata || c1_wdata !== e1_wdata)
                $display("FAIL rand_c1 a=%h sz=%0d wr=%b: got f=%b ad=%h rd=%h wd=%h, required f=%b ad=%h rd=%h wd=%h", a, sz, wr, c1_flags, c1_addr, c1_rdata, c1_wdata, e1_flags, e1_addr, e1_rdata, e1_wdata);
            else pass_cnt++;
            total_cnt++;
            if (c2_flags !== e2_flags || c2_addr !== e2_addr || c2_wdata !== e2_wdata)
                $display("FAIL rand_c2 a=%h sz=%0d: got f=%b ad=%h wd=%h, required f=%b ad=%h wd=%h", a, sz, c2_flags, c2_addr, c2_wdata, e2_flags, e2_addr, e2_wdata);
            else pass_cnt++;
        end
        for (int w = 0; w < 32; w++) begin
            model_access(32'(4*w), 2'd2, 1'b0, 1'b0, 32'h0);
            issue(32'(4*w), 2'd2, 1'b0, 1'b0, 32'h0);
            total_cnt++;
            if (c1_rdata !== e1_rdata)
                $display("FAIL sweep_word_%0d: got %h, required %h", w, c1_rdata, e1_rdata);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'd0;
        req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        test_reset();
        for (int w = 0; w < 32; w++) set_word(32'(4*w), $urandom);
        test_loads();
        test_sub_store();
        test_back_to_back();
        test_reject();
        test_reset_in_merge();
        test_random();
        @(negedge clk);
        req_valid_i = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
